// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD word sequencer:
//   - lcd_seq_state_t : sequencer FSM state encoding
//   - LCD_RS_BIT      : position of the register-select bit in a 9-bit word
//   - LCD_CMD_CLEAR   : HD44780 "clear display" command byte
//   - is_long_cmd()   : flags words that need the long execution wait
//                       (clear display 0x01, return home 0x02/0x03)
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_DONE
  } lcd_seq_state_t;

  localparam int         LCD_RS_BIT      = 8;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  // Return-home is 0000_001x: bit 0 is don't-care.
  localparam logic [6:0] LCD_CMD_HOME_HI = 7'b000_0001;

  // Only instruction-register writes (RS=0) can be slow commands.
  function automatic logic is_long_cmd(input logic [8:0] word);
    return !word[LCD_RS_BIT] &&
           ((word[7:0] == LCD_CMD_CLEAR) || (word[7:1] == LCD_CMD_HOME_HI));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// -----------------------------------------------------------------------------
// lcd_delay_counter
// 32-bit loadable down-counter that times every delayed state of the
// sequencer. To wait N cycles the owner loads N-1 on the edge that enters the
// state and leaves on the cycle where zero is high. The counter stops at 0.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset (loads RESET_VALUE)
//   load       : load load_value on the next edge
//   load_value : value to load
//   zero       : count is 0
// -----------------------------------------------------------------------------
module lcd_delay_counter #(
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic        zero
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  assign zero = (count == 32'd0);

endmodule

// File: rtl/lcd_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_sequencer
// Plays NUM_ENTRIES 9-bit words from the LCD word memory (addresses 0 upward)
// onto an HD44780-style bus with programmable setup / E-high / hold / execution
// timing. After reset it waits POWERUP_CYC cycles before accepting start.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   start    : one-cycle request to play the whole sequence
//   rd_addr  : word memory read address (equals the current entry index)
//   rd_data  : word memory read data, combinational from rd_addr; bits [8:0]
//   lcd_rs   : register select (word bit 8)
//   lcd_rw   : read/write, tied to write (0)
//   lcd_e    : enable strobe, registered
//   lcd_data : DB[7:0] (word bits 7:0)
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse after the last entry's execution wait
// Handshake: start is a plain request sampled only in IDLE; it is not queued,
// and busy low is the only indication that a request will be taken.
// -----------------------------------------------------------------------------
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int NUM_ENTRIES   = 40,
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 32,
  parameter int POWERUP_CYC   = 750000,
  parameter int SETUP_CYC     = 4,
  parameter int E_HIGH_CYC    = 12,
  parameter int HOLD_CYC      = 4,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e,
  output logic [7:0]        lcd_data,
  output logic              busy,
  output logic              done
);

  // Counter preloads are N-1 so that a stage lasts exactly N cycles.
  localparam logic [31:0] POWERUP_LOAD = 32'(POWERUP_CYC - 1);
  localparam logic [31:0] SETUP_LOAD   = 32'(SETUP_CYC - 1);
  localparam logic [31:0] PULSE_LOAD   = 32'(E_HIGH_CYC - 1);
  localparam logic [31:0] HOLD_LOAD    = 32'(HOLD_CYC - 1);
  localparam logic [31:0] EXEC_LOAD    = 32'(EXEC_CYC - 1);
  localparam logic [31:0] LONG_LOAD    = 32'(LONG_EXEC_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_ENTRIES - 1);

  lcd_seq_state_t    state;
  logic [ADDR_W-1:0] index;
  logic              cnt_load;
  logic [31:0]       cnt_value;
  logic              cnt_zero;

  // Only the low nine bits of a memory word carry LCD information.
  logic unused_rd_bits;
  assign unused_rd_bits = ^rd_data[DATA_W-1:LCD_RS_BIT+1];

  assign rd_addr = index;
  assign lcd_rw  = 1'b0;

  lcd_delay_counter #(
    .RESET_VALUE(POWERUP_LOAD)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(cnt_value),
    .zero      (cnt_zero)
  );

  // Counter reload for the stage being entered on this edge. FETCH is a fixed
  // single cycle and IDLE/DONE are untimed, so they never load.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = 32'd0;
    case (state)
      ST_FETCH: begin
        cnt_load  = 1'b1;
        cnt_value = SETUP_LOAD;
      end
      ST_SETUP: begin
        cnt_load  = cnt_zero;
        cnt_value = PULSE_LOAD;
      end
      ST_PULSE: begin
        cnt_load  = cnt_zero;
        cnt_value = HOLD_LOAD;
      end
      ST_HOLD: begin
        cnt_load  = cnt_zero;
        cnt_value = is_long_cmd({lcd_rs, lcd_data}) ? LONG_LOAD : EXEC_LOAD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_POWERUP;
      index    <= '0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_e    <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_POWERUP: begin
          if (cnt_zero) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
            index <= '0;
          end
        end
        ST_FETCH: begin
          // The bus word changes only here and stays put until the next FETCH.
          lcd_rs   <= rd_data[LCD_RS_BIT];
          lcd_data <= rd_data[7:0];
          state    <= ST_SETUP;
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            lcd_e <= 1'b1;
            state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (cnt_zero) begin
            lcd_e <= 1'b0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            if (index == LAST_INDEX) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              index <= index + ADDR_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          index <= '0;
        end
        default: begin
          state <= ST_POWERUP;
          lcd_e <= 1'b0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcd_sequencer
// Directed bench for lcd_sequencer with short timing parameters. A bench-side
// word memory feeds rd_data; a bus monitor inside tick() checks every E strobe
// against the expected word queue and the hand-computed timing.
// -----------------------------------------------------------------------------
module tb_lcd_sequencer;

  localparam int NUM_ENTRIES   = 40;
  localparam int ADDR_W        = 6;
  localparam int DATA_W        = 32;
  localparam int POWERUP_CYC   = 20;
  localparam int SETUP_CYC     = 2;
  localparam int E_HIGH_CYC    = 3;
  localparam int HOLD_CYC      = 2;
  localparam int EXEC_CYC      = 10;
  localparam int LONG_EXEC_CYC = 50;

  // ---------------- clock / reset / DUT ----------------
  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              lcd_rs;
  logic              lcd_rw;
  logic              lcd_e;
  logic [7:0]        lcd_data;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  logic [8:0] mem [64];
  assign rd_data = {23'd0, mem[rd_addr]};

  lcd_sequencer #(
    .NUM_ENTRIES  (NUM_ENTRIES),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .POWERUP_CYC  (POWERUP_CYC),
    .SETUP_CYC    (SETUP_CYC),
    .E_HIGH_CYC   (E_HIGH_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .EXEC_CYC     (EXEC_CYC),
    .LONG_EXEC_CYC(LONG_EXEC_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .lcd_data(lcd_data),
    .busy    (busy),
    .done    (done)
  );

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         t0 = 0;
  bit         mon_en = 1'b0;
  int         rise_cnt = 0;
  int         hi_len = 0;
  int         stable_run = 0;
  int         hold_left = 0;
  int         last_fall = 0;
  bit         have_fall = 1'b0;
  bit         e_prev = 1'b0;
  logic [8:0] w_prev = 9'h000;
  logic [8:0] last_word = 9'h000;
  int         exp_total = 0;
  int         done_cnt = 0;
  int         done_at_cyc = 0;
  logic [8:0] exp_q[$];
  int         gap_q[$];
  logic [8:0] def_words [40];
  logic [8:0] long_words [5];
  int         exp_wait [5];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slow HD44780 instructions: clear (0x01) and return home (0x02, 0x03).
  function automatic bit bench_long(input logic [8:0] w);
    return (w == 9'h001) || (w == 9'h002) || (w == 9'h003);
  endfunction

  // One clock: sample on the falling edge and run the bus monitor.
  task automatic tick();
    logic [8:0] w;
    @(negedge clk);
    cyc++;
    w = {lcd_rs, lcd_data};
    if (done) begin
      done_cnt++;
      done_at_cyc = cyc;
    end
    if (mon_en) begin
      stable_run = (w == w_prev) ? stable_run + 1 : 1;
      if (lcd_e && !e_prev) begin
        rise_cnt++;
        hi_len = 1;
        // Word must already have been on the bus for the 2 setup cycles.
        check_val("setup_stable", 32'(stable_run >= 3), 32'd1);
        if (exp_q.size() > 0) check_val("word", 32'(w), 32'(exp_q.pop_front()));
        else                  check_val("e_count", rise_cnt, exp_total);
      end else if (lcd_e) begin
        hi_len++;
      end
      if (!lcd_e && e_prev) begin
        check_val("e_high", hi_len, E_HIGH_CYC);
        if (have_fall) begin
          gap_q.push_back(cyc - last_fall);
          check_val("fall_gap", cyc - last_fall, bench_long(last_word) ? 58 : 18);
        end
        have_fall = 1'b1;
        last_fall = cyc;
        last_word = w;
        hold_left = 2;
      end else if (hold_left > 0) begin
        hold_left--;
        check_val("hold_stable", 32'(w), 32'(last_word));
      end
    end else begin
      rise_cnt   = 0;
      hi_len     = 0;
      stable_run = 0;
      hold_left  = 0;
      have_fall  = 1'b0;
    end
    e_prev = lcd_e;
    w_prev = w;
  endtask

  // Hold reset, release just after a rising edge, and time the powerup wait.
  task automatic powerup(input bit pulse_start);
    int first_idle;
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    check_val("rst_outputs", 32'({rd_addr, lcd_rs, lcd_rw, lcd_e, lcd_data, done}), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    first_idle = -1;
    for (int j = 0; j < 26; j++) begin
      tick();
      if (!busy && first_idle < 0) first_idle = j;
      if (pulse_start) start = (j == 4);
    end
    start = 1'b0;
    check_val("powerup_len", first_idle, POWERUP_CYC);
    check_val("idle_after_powerup", 32'({busy, lcd_e, rd_addr}), 32'd0);
  endtask

  task automatic start_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    check_val("fetch_busy", 32'(busy), 32'd1);
    check_val("fetch_addr", 32'(rd_addr), 32'd0);
  endtask

  task automatic load_default();
    exp_q.delete();
    gap_q.delete();
    for (int i = 0; i < 64; i++) mem[i] = (i < 40) ? def_words[i] : 9'h120;
    for (int i = 0; i < 40; i++) exp_q.push_back(def_words[i]);
    exp_total = NUM_ENTRIES;
    done_cnt  = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int g;
    def_words = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080,
                  9'h120, 9'h148, 9'h145, 9'h14C, 9'h14C, 9'h14F, 9'h120, 9'h157,
                  9'h14F, 9'h152, 9'h14C, 9'h144, 9'h121, 9'h120, 9'h120, 9'h120,
                  9'h0C0,
                  9'h146, 9'h150, 9'h147, 9'h141, 9'h120, 9'h14C, 9'h143, 9'h144,
                  9'h120, 9'h154, 9'h145, 9'h153, 9'h154, 9'h120, 9'h14F, 9'h14B,
                  9'h121, 9'h120};
    long_words = '{9'h002, 9'h003, 9'h102, 9'h001, 9'h004};
    exp_wait   = '{50, 50, 10, 50, 10};
    load_default();
    #3;

    // Reset and powerup, with a start pulse that must be ignored.
    powerup(1'b1);

    // Full default sequence with stray start pulses mid-sequence.
    load_default();
    mon_en = 1'b1;
    start_seq();
    while (cyc - t0 < 800) begin
      tick();
      start = ((cyc - t0) == 100) || ((cyc - t0) == 400);
    end
    start = 1'b0;
    check_val("done_count", done_cnt, 1);
    check_val("done_time", done_at_cyc - t0, 760);
    check_val("e_pulses", rise_cnt, 40);
    check_val("words_left", exp_q.size(), 0);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_addr", 32'(rd_addr), 32'd0);
    mon_en = 1'b0;
    tick();

    // Restart after done, then reset while E is high on entry 7.
    load_default();
    mon_en = 1'b1;
    start_seq();
    n = 0;
    while (rise_cnt != 8 && n < 400) begin
      tick();
      n++;
    end
    check_val("reach_entry7", rise_cnt, 8);
    check_val("entry7_e_high", 32'(lcd_e), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("rst_e_drop", 32'(lcd_e), 32'd0);
    check_val("rst_busy_mid", 32'(busy), 32'd1);
    mon_en = 1'b0;
    exp_q.delete();
    powerup(1'b0);
    check_val("no_done_after_rst", done_cnt, 0);

    // Long-command detection; playback restarts at address 0.
    load_default();
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      mem[i] = (i < 5) ? long_words[i] : 9'h120;
      exp_q.push_back(mem[i]);
    end
    mon_en = 1'b1;
    start_seq();
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      tick();
      n++;
    end
    check_val("long_done_seen", done_cnt, 1);
    check_val("long_done_time", done_at_cyc - t0, 840);
    for (int i = 0; i < 5; i++) begin
      g = (i < gap_q.size()) ? gap_q[i] - 8 : -1;
      check_val($sformatf("wait_len_%0d", i), g, exp_wait[i]);
    end
    mon_en = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
